// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and SRAM geometry for the memory-stage controller
package mem_ctrl_pkg;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
endpackage

// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if: memory-stage request/response bus between pipeline and controller
interface sram_mem_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] st_val;
    logic [31:0] rdata;
    logic        ready;
    modport master(output rd_en, wr_en, address, st_val, input rdata, ready);
    modport slave(input rd_en, wr_en, address, st_val, output rdata, ready);
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: saturating phase counter flagging the last wait-state cycle
module sram_wait_counter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic last
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    logic [CW-1:0] cnt;
    assign last = cnt == CW'(ACCESS_CYCLES - 1);
    // count up within a phase, clear on every state change, park on the last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (!last) cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: sequences 32-bit loads/stores as two 16-bit async SRAM accesses
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_mem_controller_if.slave bus,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);
    state_t state, state_nx;
    logic        last, wr_ph;
    logic [16:0] widx;
    logic [31:0] wdata_q, rdata_q;

    assign widx = 17'((bus.address - BASE_ADDR) >> 2);

    sram_wait_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_nx != state),
        .last (last)
    );

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next state: write has priority, phases advance on the last wait cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.wr_en ? WR_LO : bus.rd_en ? RD_LO : IDLE;
            RD_LO:   state_nx = last ? RD_HI : RD_LO;
            RD_HI:   state_nx = last ? DONE : RD_HI;
            WR_LO:   state_nx = last ? WR_HI : WR_LO;
            WR_HI:   state_nx = last ? DONE : WR_HI;
            default: state_nx = IDLE;
        endcase
    end

    // latch address/store data on IDLE exit, step to the odd half-word, capture read halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && state_nx != IDLE) begin
                sram_addr <= {widx, 1'b0};
                wdata_q   <= bus.st_val;
            end
            if ((state == RD_LO || state == WR_LO) && last) sram_addr[0] <= 1'b1;
            if (state == RD_LO && last) rdata_q[15:0] <= sram_dq;
            if (state == RD_HI && last) rdata_q[31:16] <= sram_dq;
        end
    end

    assign wr_ph     = state == WR_LO || state == WR_HI;
    assign sram_we_n = !(wr_ph && !last);
    assign sram_dq   = wr_ph ? (state == WR_HI ? wdata_q[31:16] : wdata_q[15:0]) : 'z;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign bus.rdata = rdata_q;
    assign bus.ready = state == DONE || (state == IDLE && !bus.wr_en && !bus.rd_en);
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: table-driven and scoreboard checks against a behavioural SRAM model
module tb_sram_mem_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_mem_controller_if bus();
    sram_mem_controller_if bus3();
    wire  [15:0] sram_dq, sram_dq3;
    logic [17:0] sram_addr, sram_addr3;
    logic we_n, ce_n, oe_n, ub_n, lb_n;
    logic we_n3, ce_n3, oe_n3, ub_n3, lb_n3;

    sram_mem_controller #(.ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(we_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );
    sram_mem_controller #(.ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .sram_addr(sram_addr3), .sram_dq(sram_dq3),
        .sram_we_n(we_n3), .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_ub_n(ub_n3), .sram_lb_n(lb_n3)
    );

    logic [15:0] mem  [0:255] = '{default: 16'h0};
    logic [15:0] mem3 [0:255] = '{default: 16'h0};
    logic model_oe = 1'b0;
    int pulses = 0;
    int pulses3 = 0;
    assign sram_dq = model_oe ? mem[sram_addr[7:0]] : 'z;
    always @(posedge we_n) if (rst_n) mem[sram_addr[7:0]] <= sram_dq;
    always @(posedge we_n3) if (rst_n) mem3[sram_addr3[7:0]] <= sram_dq3;
    always @(negedge we_n) pulses <= pulses + 1;
    always @(negedge we_n3) pulses3 <= pulses3 + 1;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [17:0] lo;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // call just after a rising edge; returns just after the edge that ends DONE
    task automatic txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [17:0] lo_a, output logic [17:0] hi_a,
                       output logic we_ok, output logic [31:0] rd_val);
        lat = -1; lo_a = '0; hi_a = '0; we_ok = 1'b1; rd_val = '0;
        bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.st_val = d; model_oe = r && !w;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 1) lo_a = sram_addr;
            if (n == 3) hi_a = sram_addr;
            if (!w && !we_n) we_ok = 1'b0;
            if (bus.ready) begin
                lat = n;
                rd_val = bus.rdata;
                break;
            end
        end
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; model_oe = 1'b0;
    endtask

    initial begin
        int lat, p0, c0, n3;
        logic [17:0] lo_a, hi_a;
        logic we_ok;
        logic [31:0] rd_val, last_rd;
        bus.rd_en = 0; bus.wr_en = 0; bus.address = 0; bus.st_val = 0;
        bus3.rd_en = 0; bus3.wr_en = 0; bus3.address = 0; bus3.st_val = 0;
        vecs[0]  = '{1'b1, 32'd1024,     32'hDEADBEEF, 32'h0,        18'h00000};
        vecs[1]  = '{1'b0, 32'd1024,     32'h0,        32'hDEADBEEF, 18'h00000};
        vecs[2]  = '{1'b1, 32'd1028,     32'hCAFEF00D, 32'h0,        18'h00002};
        vecs[3]  = '{1'b0, 32'd1028,     32'h0,        32'hCAFEF00D, 18'h00002};
        vecs[4]  = '{1'b1, 32'd1027,     32'h11223344, 32'h0,        18'h00000};
        vecs[5]  = '{1'b0, 32'd1024,     32'h0,        32'h11223344, 18'h00000};
        vecs[6]  = '{1'b0, 32'd1028,     32'h0,        32'hCAFEF00D, 18'h00002};
        vecs[7]  = '{1'b1, 32'h00080400, 32'h55667788, 32'h0,        18'h00000};
        vecs[8]  = '{1'b0, 32'd1024,     32'h0,        32'h55667788, 18'h00000};
        vecs[9]  = '{1'b1, 32'd1020,     32'hA5A55A5A, 32'h0,        18'h3FFFE};
        vecs[10] = '{1'b0, 32'd1020,     32'h0,        32'hA5A55A5A, 18'h3FFFE};
        vecs[11] = '{1'b0, 32'd1027,     32'h0,        32'hA5A55A5A, 18'h00000};
        vecs[11].exp_rd = 32'h55667788;

        @(negedge clk);
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset we_n", 32'(we_n), 32'd1);
        check("reset rdata", bus.rdata, 32'h0);
        check("reset sram_addr", 32'(sram_addr), 32'h0);
        check("reset ties", {28'h0, ce_n, oe_n, ub_n, lb_n}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        last_rd = 32'h0;
        foreach (vecs[i]) begin
            p0 = pulses;
            if (!vecs[i].w) exp_q.push_back(vecs[i].exp_rd);
            txn(vecs[i].w, !vecs[i].w, vecs[i].a, vecs[i].d, lat, lo_a, hi_a, we_ok, rd_val);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd5);
            check($sformatf("v%0d lo addr", i), 32'(lo_a), 32'(vecs[i].lo));
            check($sformatf("v%0d hi addr", i), 32'(hi_a), 32'(vecs[i].lo | 18'h1));
            if (vecs[i].w) begin
                check($sformatf("v%0d we pulses", i), 32'(pulses - p0), 32'd2);
                check($sformatf("v%0d mem lo", i), 32'(mem[vecs[i].lo[7:0]]), 32'(vecs[i].d[15:0]));
                check($sformatf("v%0d mem hi", i), 32'(mem[vecs[i].lo[7:0] | 8'h1]), 32'(vecs[i].d[31:16]));
                check($sformatf("v%0d rdata kept", i), bus.rdata, last_rd);
            end else begin
                check($sformatf("v%0d rdata", i), rd_val, exp_q.size() > 0 ? exp_q.pop_front() : 32'hx);
                check($sformatf("v%0d no we in read", i), 32'(we_ok), 32'd1);
                last_rd = rd_val;
            end
        end

        c0 = cyc;
        txn(1'b1, 1'b0, 32'd1032, 32'h12345678, lat, lo_a, hi_a, we_ok, rd_val);
        check("b2b wr latency", 32'(lat), 32'd5);
        exp_q.push_back(32'h12345678);
        txn(1'b0, 1'b1, 32'd1032, 32'h0, lat, lo_a, hi_a, we_ok, rd_val);
        check("b2b rd latency", 32'(lat), 32'd5);
        check("b2b rdata", rd_val, exp_q.pop_front());
        check("b2b rd lo addr", 32'(lo_a), 32'd4);
        check("b2b elapsed", 32'(cyc - c0), 32'd12);

        bus.wr_en = 1'b1; bus.address = 32'd1040; bus.st_val = 32'h99998888;
        repeat (3) @(posedge clk);
        #2;
        check("abort in WR_HI we_n low", 32'(we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort we_n", 32'(we_n), 32'd1);
        check("abort rdata", bus.rdata, 32'h0);
        bus.wr_en = 1'b0;
        #1;
        check("abort ready", 32'(bus.ready), 32'd1);
        check("abort sram_addr", 32'(sram_addr), 32'h0);
        check("abort partial lo", 32'(mem[8]), 32'h8888);
        check("abort partial hi", 32'(mem[9]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset ready", 32'(bus.ready), 32'd1);

        p0 = pulses3;
        n3 = -1;
        bus3.wr_en = 1'b1; bus3.rd_en = 1'b1; bus3.address = 32'd1032; bus3.st_val = 32'h0BADF00D;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus3.ready) begin
                n3 = n;
                break;
            end
        end
        @(posedge clk); #1;
        bus3.wr_en = 1'b0; bus3.rd_en = 1'b0;
        check("both req latency", 32'(n3), 32'd7);
        check("both req we pulses", 32'(pulses3 - p0), 32'd2);
        check("both req mem lo", 32'(mem3[4]), 32'hF00D);
        check("both req mem hi", 32'(mem3[5]), 32'h0BAD);
        check("both req rdata", bus3.rdata, 32'h0);
        @(negedge clk);
        check("both req idle ready", 32'(bus3.ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
